tex_refill_engine: RTL and testbench

//  Memory-side responder for the texture cache miss-refill port. Accepts one line-refill

---
 rtl/tex_pkg.sv | 13 +
 rtl/tex_line_assembler.sv | 42 ++++
 rtl/tex_refill_engine.sv | 115 +++++++++++
 tb/tb_tex_refill_engine.sv | 249 ++++++++++++++++++++++++
 4 files changed

// File: rtl/tex_pkg.sv
// Shared types and sizing for the texture cache refill engine.
package tex_pkg;
  typedef enum logic [1:0] {IDLE, FETCH, RESP} refill_state_e;

  localparam int TEX_LINE_BYTES = 64;
  localparam int TEX_BEAT_BYTES = 4;
  localparam int TEX_LINE_BITS  = TEX_LINE_BYTES * 8;

  // Counter width that stays legal when the count range collapses to 1.
  function automatic int cnt_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction
endpackage

// File: rtl/tex_line_assembler.sv
// Collects in-order memory beats into one cache line; publishes the line when its last beat lands.
module tex_line_assembler
  import tex_pkg::*;
#(
  parameter int BEATS     = 16,
  parameter int BEAT_BITS = 32,
  parameter int RCV_W     = 4
)(
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       i_clear,
  input  logic                       i_strobe,
  input  logic [BEAT_BITS-1:0]       i_data,
  output logic                       o_last,
  output logic [BEATS*BEAT_BITS-1:0] o_line
);
  logic [RCV_W-1:0]                  r_cnt;
  logic [BEATS-1:0][BEAT_BITS-1:0]   r_line;
  logic [BEATS-1:0][BEAT_BITS-1:0]   r_out;
  logic [BEATS-1:0][BEAT_BITS-1:0]   w_next;

  assign o_last = i_strobe && (r_cnt == RCV_W'(BEATS - 1));
  assign o_line = r_out;

  for (genvar k = 0; k < BEATS; k++) begin : g_beat
    assign w_next[k] = (i_strobe && r_cnt == RCV_W'(k)) ? i_data : r_line[k];
  end

  // r_out is only refreshed on completion so the previous line stays visible during the next fetch.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_cnt  <= '0;
      r_line <= '0;
      r_out  <= '0;
    end else begin
      r_line <= w_next;
      if (i_clear)       r_cnt <= '0;
      else if (i_strobe) r_cnt <= r_cnt + RCV_W'(1);
      if (o_last)        r_out <= w_next;
    end
  end
endmodule

// File: rtl/tex_refill_engine.sv
// Texture cache miss-refill responder: splits one line request into in-order beat reads and returns the line.
module tex_refill_engine
  import tex_pkg::*;
#(
  parameter int LINE_BYTES      = TEX_LINE_BYTES,
  parameter int BEAT_BYTES      = TEX_BEAT_BYTES,
  parameter int MAX_OUTSTANDING = 4
)(
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    miss_req_valid,
  input  logic [31:0]             miss_req_addr,
  output logic                    miss_req_ready,
  output logic                    miss_resp_valid,
  output logic [LINE_BYTES*8-1:0] miss_resp_data,
  output logic                    miss_resp_err,
  output logic                    mem_req_valid,
  output logic [31:0]             mem_req_addr,
  input  logic                    mem_req_ready,
  input  logic                    mem_resp_valid,
  input  logic [BEAT_BYTES*8-1:0] mem_resp_data,
  input  logic                    mem_resp_err,
  output logic [15:0]             refill_count
);
  localparam int BEATS       = LINE_BYTES / BEAT_BYTES;
  localparam int OFFSET_BITS = $clog2(LINE_BYTES);
  localparam int BEAT_BITS   = BEAT_BYTES * 8;
  localparam int RCV_W       = cnt_width(BEATS);
  localparam int ISS_W       = cnt_width(BEATS + 1);
  localparam int OUT_W       = cnt_width(MAX_OUTSTANDING + 1);

  refill_state_e     r_state, w_next_state;
  logic [31:0]       r_addr;
  logic [ISS_W-1:0]  r_issue;
  logic [OUT_W-1:0]  r_outst;
  logic              r_err;
  logic [15:0]       r_refill_cnt;
  logic              w_accept, w_issue, w_ret, w_last;

  assign w_issue        = mem_req_valid && mem_req_ready;
  // Returns outside FETCH are leftovers from an aborted refill and are dropped.
  assign w_ret          = (r_state == FETCH) && mem_resp_valid;
  assign miss_resp_err  = miss_resp_valid && r_err;
  assign mem_req_addr   = r_addr;
  assign refill_count   = r_refill_cnt;

  always_comb begin
    w_next_state    = r_state;
    w_accept        = 1'b0;
    miss_req_ready  = 1'b0;
    miss_resp_valid = 1'b0;
    mem_req_valid   = 1'b0;
    case (r_state)
      IDLE: begin
        miss_req_ready = 1'b1;
        if (miss_req_valid) begin
          w_accept     = 1'b1;
          w_next_state = FETCH;
        end
      end
      FETCH: begin
        // Both limits only move on a handshake, so a raised request is never withdrawn.
        mem_req_valid = (r_issue < ISS_W'(BEATS)) && (r_outst < OUT_W'(MAX_OUTSTANDING));
        if (w_last) w_next_state = RESP;
      end
      RESP: begin
        miss_resp_valid = 1'b1;
        w_next_state    = IDLE;
      end
      default: w_next_state = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state      <= IDLE;
      r_addr       <= '0;
      r_issue      <= '0;
      r_outst      <= '0;
      r_err        <= 1'b0;
      r_refill_cnt <= '0;
    end else begin
      r_state <= w_next_state;
      if (w_accept) begin
        r_addr  <= {miss_req_addr[31:OFFSET_BITS], {OFFSET_BITS{1'b0}}};
        r_issue <= '0;
        r_outst <= '0;
        r_err   <= 1'b0;
      end else begin
        if (w_issue) begin
          r_issue <= r_issue + ISS_W'(1);
          r_addr  <= r_addr + 32'(BEAT_BYTES);
        end
        if (w_issue && !w_ret)      r_outst <= r_outst + OUT_W'(1);
        else if (!w_issue && w_ret) r_outst <= r_outst - OUT_W'(1);
        if (w_ret && mem_resp_err)  r_err   <= 1'b1;
      end
      if (miss_resp_valid) r_refill_cnt <= r_refill_cnt + 16'd1;
    end
  end

  tex_line_assembler #(
    .BEATS     (BEATS),
    .BEAT_BITS (BEAT_BITS),
    .RCV_W     (RCV_W)
  ) u_asm (
    .clk      (clk),
    .rst      (rst),
    .i_clear  (w_accept),
    .i_strobe (w_ret),
    .i_data   (mem_resp_data),
    .o_last   (w_last),
    .o_line   (miss_resp_data)
  );
endmodule

// File: tb/tb_tex_refill_engine.sv
// Randomized bench for tex_refill_engine with a transaction-level memory and line model.
module tb_tex_refill_engine;
  logic         clk = 1'b0, rst = 1'b1;
  logic         miss_req_valid = 1'b0;
  logic [31:0]  miss_req_addr = '0;
  logic         miss_req_ready, miss_resp_valid, miss_resp_err, mem_req_valid;
  logic [511:0] miss_resp_data;
  logic [31:0]  mem_req_addr;
  logic         mem_req_ready = 1'b0, mem_resp_valid = 1'b0, mem_resp_err = 1'b0;
  logic [31:0]  mem_resp_data = '0;
  logic [15:0]  refill_count;

  always #5 clk = ~clk;

  tex_refill_engine dut (
    .clk(clk), .rst(rst),
    .miss_req_valid(miss_req_valid), .miss_req_addr(miss_req_addr), .miss_req_ready(miss_req_ready),
    .miss_resp_valid(miss_resp_valid), .miss_resp_data(miss_resp_data), .miss_resp_err(miss_resp_err),
    .mem_req_valid(mem_req_valid), .mem_req_addr(mem_req_addr), .mem_req_ready(mem_req_ready),
    .mem_resp_valid(mem_resp_valid), .mem_resp_data(mem_resp_data), .mem_resp_err(mem_resp_err),
    .refill_count(refill_count)
  );

  int n_chk = 0, n_pass = 0, cyc = 0;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", nm, act, exp);
  endtask

  task automatic chk_line(input string nm, input logic [511:0] act, input logic [511:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", nm, act, exp);
  endtask

  // Memory content: beat k of the current line is g_pat + k*g_step, error if g_errmask[k].
  logic [31:0] g_pat = '0, g_step = 32'd1;
  logic [15:0] g_errmask = '0;
  int          g_lat = 1, g_mode = 0;

  typedef struct { logic [31:0] data; logic err; int due; } beat_t;
  beat_t memq[$];
  int    last_due = 0;

  function automatic logic [511:0] exp_line();
    logic [511:0] l;
    for (int k = 0; k < 16; k++) l[k*32 +: 32] = g_pat + 32'(k) * g_step;
    return l;
  endfunction

  // Model state
  bit          active = 0;
  logic [31:0] base = '0;
  int issued = 0, returned = 0, max_out = 0, exp_cnt = 0;
  int n_acc = 0, n_resp = 0, acc_cyc = 0, resp_cyc = 0, stray = 0;
  int stall_n = 0, stall_cyc = 0;
  logic [31:0] stall_addr = '0;
  logic        resp_err_seen = 1'b0;
  bit          m_expv, m_expr;
  int          m_k, m_lat;
  beat_t       m_b;

  // Compare process: checks every cycle from the state of the previous cycles, then folds in this cycle.
  always @(negedge clk) begin
    if (rst) begin
      chk("rst_ready", miss_req_ready, 1);
      chk("rst_mem_valid", mem_req_valid, 0);
      chk("rst_resp_valid", miss_resp_valid, 0);
      chk("rst_resp_err", miss_resp_err, 0);
      chk("rst_count", refill_count, 0);
      chk("rst_mem_addr", mem_req_addr, 0);
      chk_line("rst_data", miss_resp_data, '0);
      active  = 0;
      exp_cnt = 0;
    end else begin
      m_expv = active && issued < 16 && (issued - returned) < 4;
      m_expr = active && returned == 16;
      chk("req_ready", miss_req_ready, !active);
      chk("mem_valid", mem_req_valid, m_expv);
      chk("resp_valid", miss_resp_valid, m_expr);
      chk("refill_count", refill_count, exp_cnt[15:0]);
      if (mem_req_valid) chk("mem_addr", mem_req_addr, base + 32'(4 * issued));
      if (mem_req_valid && !mem_req_ready) begin
        stall_cyc++;
        stall_addr = mem_req_addr;
      end
      if (mem_req_valid && mem_req_ready) begin
        m_k = int'((mem_req_addr >> 2) & 32'hF);
        m_b.data = g_pat + 32'(m_k) * g_step;
        m_b.err  = g_errmask[m_k];
        m_lat = (g_lat == 0) ? int'($urandom_range(1, 6)) : g_lat;
        m_b.due = cyc + m_lat;
        if (m_b.due < last_due) m_b.due = last_due;
        last_due = m_b.due;
        memq.push_back(m_b);
        issued++;
      end
      if (mem_resp_valid) begin
        if (active && returned < 16) returned++;
        else stray++;
      end
      if (issued - returned > max_out) max_out = issued - returned;
      if (miss_resp_valid) begin
        chk_line("resp_data", miss_resp_data, exp_line());
        chk("resp_err", miss_resp_err, |g_errmask);
        resp_err_seen = miss_resp_err;
        n_resp++;
        resp_cyc = cyc;
        active   = 0;
        exp_cnt  = (exp_cnt + 1) & 16'hFFFF;
      end
      if (miss_req_valid && miss_req_ready) begin
        active = 1;
        base = miss_req_addr & ~32'h3F;
        issued = 0;
        returned = 0;
        n_acc++;
        acc_cyc = cyc;
      end
    end
  end

  // Memory driver: ready policy by mode, in-order returns after each beat's latency.
  always @(posedge clk) begin
    cyc++;
    #1;
    case (g_mode)
      1: if (mem_req_valid && issued == 5 && stall_n < 3) begin
           mem_req_ready = 1'b0;
           stall_n++;
         end else mem_req_ready = 1'b1;
      2: mem_req_ready = ($urandom % 4) != 0;
      default: mem_req_ready = 1'b1;
    endcase
    if (memq.size() > 0 && memq[0].due <= cyc) begin
      mem_resp_valid = 1'b1;
      mem_resp_data  = memq[0].data;
      mem_resp_err   = memq[0].err;
      void'(memq.pop_front());
    end else begin
      mem_resp_valid = 1'b0;
      mem_resp_data  = '0;
      mem_resp_err   = 1'b0;
    end
  end

  task automatic refill(input logic [31:0] addr, input logic [31:0] pat, input logic [31:0] step,
                        input logic [15:0] em, input int lat, input int mode, input bit hold);
    int t, a0, r0;
    a0 = n_acc; r0 = n_resp;
    g_pat = pat; g_step = step; g_errmask = em; g_lat = lat; g_mode = mode;
    stall_n = 0; stall_cyc = 0; max_out = 0;
    @(posedge clk); #2;
    miss_req_valid = 1'b1;
    miss_req_addr  = addr;
    t = 0;
    while (n_acc == a0 && t < 100) begin @(posedge clk); #2; t++; end
    chk("accepted", n_acc - a0, 1);
    if (!hold) miss_req_valid = 1'b0;
    t = 0;
    while (n_resp == r0 && t < 2000) begin @(posedge clk); #2; t++; end
    chk("resp_seen", n_resp - r0, 1);
    chk("one_accept", n_acc - a0, 1);
  endtask

  initial begin
    int t, r0, s0;
    repeat (3) @(posedge clk);
    #2 rst = 1'b0;

    // 1: zero-wait memory, address offset ignored, beat pattern and latency pinned
    refill(32'h0000_1234, 32'hA000_0000, 32'd1, 16'h0, 1, 0, 0);
    chk("t1_base", base, 32'h1200);
    chk("t1_latency", resp_cyc - acc_cyc, 18);
    chk("t1_word0", miss_resp_data[31:0], 32'hA000_0000);
    chk("t1_word5", miss_resp_data[5*32 +: 32], 32'hA000_0005);
    chk("t1_word15", miss_resp_data[15*32 +: 32], 32'hA000_000F);
    chk("t1_count", refill_count, 16'd1);
    chk("t1_err", resp_err_seen, 0);

    // 2: ready stalled three cycles on beat 5
    refill(32'h0000_1200, 32'hB000_0000, 32'd1, 16'h0, 1, 1, 0);
    chk("t2_stalls", stall_cyc, 3);
    chk("t2_stall_addr", stall_addr, 32'h1214);
    chk("t2_word5", miss_resp_data[5*32 +: 32], 32'hB000_0005);

    // 3: long latency caps outstanding reads
    refill(32'h8000_0047, $urandom, $urandom, 16'h0, 10, 0, 0);
    chk("t3_max_outstanding", max_out, 4);

    // 4: error on beat 7 only, then a clean refill
    refill(32'h0004_0000, $urandom, $urandom, 16'h0080, 2, 2, 0);
    chk("t4_err", resp_err_seen, 1);
    refill(32'h0004_0040, $urandom, $urandom, 16'h0, 2, 2, 0);
    chk("t4_next_err", resp_err_seen, 0);

    // 5: request held through the refill is accepted once, next request right after RESP
    refill(32'h0000_2000, $urandom, $urandom, 16'h0, 1, 0, 1);
    r0 = n_acc; t = 0;
    while (n_acc == r0 && t < 20) begin @(posedge clk); #2; t++; end
    chk("t5_reaccept", n_acc - r0, 1);
    chk("t5_gap", acc_cyc - resp_cyc, 1);
    miss_req_valid = 1'b0;
    r0 = n_resp; t = 0;
    while (n_resp == r0 && t < 2000) begin @(posedge clk); #2; t++; end
    chk("t5_second_resp", n_resp - r0, 1);

    // randomized refills
    for (int i = 0; i < 20; i++)
      refill($urandom, $urandom, $urandom, 16'($urandom & $urandom & $urandom),
             int'($urandom_range(0, 8)), ($urandom % 2) ? 2 : 0, 0);

    // 6: reset mid-fetch, stale returns dropped, clean refill afterwards
    g_pat = 32'hC000_0000; g_step = 32'd1; g_errmask = '0; g_lat = 3; g_mode = 0;
    @(posedge clk); #2;
    miss_req_valid = 1'b1; miss_req_addr = 32'h0000_3000;
    r0 = n_acc; t = 0;
    while (n_acc == r0 && t < 100) begin @(posedge clk); #2; t++; end
    miss_req_valid = 1'b0;
    t = 0;
    while (returned < 4 && t < 100) begin @(posedge clk); #2; t++; end
    chk("t6_mid_fetch", active && returned >= 4 && returned < 16, 1);
    r0 = n_resp; s0 = stray;
    rst = 1'b1;
    @(posedge clk); #2;
    rst = 1'b0;
    t = 0;
    while (memq.size() > 0 && t < 100) begin @(posedge clk); #2; t++; end
    repeat (3) @(posedge clk);
    #2;
    chk("t6_no_resp", n_resp - r0, 0);
    chk("t6_stray_seen", stray > s0, 1);
    chk("t6_count_after_rst", refill_count, 0);
    refill(32'h0000_3000, 32'hD000_0000, 32'd1, 16'h0, 1, 0, 0);
    chk("t6_count", refill_count, 16'd1);
    chk("t6_word3", miss_resp_data[3*32 +: 32], 32'hD000_0003);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not complete, %0d/%0d passed", n_pass, n_chk);
    $fatal(1);
  end
endmodule
